// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled synchronous RAM controller:
// transfer-size encodings, controller state type and the wait-state limit.
package ram_pkg;

    typedef enum logic [1:0] {
        DT_BYTE  = 2'b00,
        DT_HALF  = 2'b01,
        DT_WORD  = 2'b10,
        DT_DWORD = 2'b11
    } data_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DONE,
        ST_RELEASE
    } state_t;

    localparam int WAIT_CYCLES_MAX = 15;

    // Natural alignment: halfwords on even addresses, words/doublewords on multiples of 4.
    function automatic logic is_misaligned(input data_type_t dt, input logic [1:0] a_lo);
        case (dt)
            DT_BYTE: return 1'b0;
            DT_HALF: return a_lo[0];
            default: return a_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ram_array_be.sv
// Byte-wide storage with a 4-byte big-endian port: lane 0 is the lowest address and maps
// to data[31:24]. Lane addresses wrap modulo the array depth; writes are byte-enabled.
module ram_array_be #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] lane_addr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi]           = addr + ADDR_W'(gi);
            assign rdata[31-8*gi -: 8]     = mem[lane_addr[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[lane_addr[i]] <= wdata[31-8*i -: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ram_sync_be.sv
// Request/complete controller for a byte-addressed RAM with wait states and doubleword bursts.
// Optional macro RAM_ALIGN_CHECK_EN adds a Fault output and suppresses misaligned accesses.
module ram_sync_be
    import ram_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MOV,
    input  logic              ReadWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    input  logic [1:0]        DataType,
    input  logic              SIGN,
    output logic [31:0]       DataOut,
    output logic              MOC,
`ifdef RAM_ALIGN_CHECK_EN
    output logic              Fault,
`endif
    output logic              Busy
);

    localparam int         WAIT_EFF  = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF);
    localparam state_t     BEAT_FIRST_STATE = (WAIT_EFF == 0) ? ST_XFER : ST_WAIT;

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    data_type_t        dt_reg;
    logic              sign_reg;
    logic [31:0]       wdata_reg;
    logic              second_reg;

    logic              access_ok;
    logic              abort_burst;
    logic              arr_we;
    logic [3:0]        arr_be;
    logic [31:0]       arr_wdata;
    logic [31:0]       arr_rdata;
    logic [31:0]       read_ext;

`ifdef RAM_ALIGN_CHECK_EN
    assign access_ok   = !is_misaligned(dt_reg, addr_reg[1:0]);
    assign abort_burst = Fault;
`else
    assign access_ok   = 1'b1;
    assign abort_burst = 1'b0;
`endif

    // Gating with reset keeps a write coincident with reset assertion from landing.
    assign arr_we = (state_reg == ST_XFER) && !rw_reg && access_ok && !reset;

    always_comb begin
        arr_be    = 4'b1111;
        arr_wdata = wdata_reg;
        read_ext  = arr_rdata;
        case (dt_reg)
            DT_BYTE: begin
                arr_be    = 4'b0001;
                arr_wdata = {wdata_reg[7:0], 24'h0};
                read_ext  = {{24{sign_reg & arr_rdata[31]}}, arr_rdata[31:24]};
            end
            DT_HALF: begin
                arr_be    = 4'b0011;
                arr_wdata = {wdata_reg[15:0], 16'h0};
                read_ext  = {{16{sign_reg & arr_rdata[31]}}, arr_rdata[31:16]};
            end
            default: ;
        endcase
    end

    ram_array_be #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (addr_reg),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            rw_reg     <= 1'b0;
            addr_reg   <= '0;
            dt_reg     <= DT_BYTE;
            sign_reg   <= 1'b0;
            wdata_reg  <= 32'h0;
            second_reg <= 1'b0;
            DataOut    <= 32'h0;
            MOC        <= 1'b0;
            Busy       <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
            Fault      <= 1'b0;
`endif
        end else begin
            MOC <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
            Fault <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (MOV) begin
                        rw_reg     <= ReadWrite;
                        addr_reg   <= Address;
                        dt_reg     <= data_type_t'(DataType);
                        sign_reg   <= SIGN;
                        wdata_reg  <= DataIn;
                        second_reg <= 1'b0;
                        cnt_reg    <= WAIT_LOAD;
                        Busy       <= 1'b1;
                        state_reg  <= BEAT_FIRST_STATE;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1) begin
                        state_reg <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (rw_reg && access_ok) begin
                        DataOut <= read_ext;
                    end
`ifdef RAM_ALIGN_CHECK_EN
                    Fault <= !access_ok;
`endif
                    MOC       <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    // Second doubleword beat only if the requester is still asking for it.
                    if (dt_reg == DT_DWORD && !second_reg && MOV && !abort_burst) begin
                        second_reg <= 1'b1;
                        addr_reg   <= addr_reg + ADDR_W'(4);
                        wdata_reg  <= DataIn;
                        cnt_reg    <= WAIT_LOAD;
                        state_reg  <= BEAT_FIRST_STATE;
                    end else begin
                        state_reg <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!MOV) begin
                        Busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
